cv32e40p_apu_arbiter: RTL
=========================

// Module: cv32e40p_apu_arbiter
// PURPOSE
//  Shares one APU/FPU instance (cv32e40p_fp_wrapper-style port) between N_REQ requesters (cores/accelerators).
//  Round-robin arbitration on the request channel; requester ID travels as tag, response demuxed by returned tag.
//  Per-requester outstanding-credit tracking. The FPU response channel has no backpressure, so each requester
//  must sink rvalid unconditionally. Sits between the requester APU ports and the FPU wrapper.
// PARAMETERS
//  N_REQ        2  number of requesters (>=2)
//  MAX_OUTST    4  max in-flight ops per requester (>=1); counter width CNT_W = $clog2(MAX_OUTST+1)
//  RESP_REG     0  0: response path combinational; 1: response path registered (+1 cycle)
//  ID_W is a localparam, $clog2(N_REQ).
// PORTS
//  clk_i          in   1                        clock
//  rst_ni         in   1                        asynchronous active-low reset
//  req_i          in   N_REQ                    per-requester request
//  gnt_o          out  N_REQ                    per-requester grant (one-hot or zero)
//  operands_i     in   N_REQ x NARGS x 32       per-requester operands (APU_NARGS_CPU)
//  op_i           in   N_REQ x APU_WOP_CPU      per-requester op
//  flags_i        in   N_REQ x APU_NDSFLAGS_CPU per-requester flags
//  rvalid_o       out  N_REQ                    per-requester response valid (one-hot or zero)
//  rdata_o        out  32                       response data, broadcast
//  rflags_o       out  APU_NUSFLAGS_CPU         response status flags, broadcast
//  apu_req_o      out  1                        to FPU: request
//  apu_gnt_i      in   1                        from FPU: in_ready
//  apu_operands_o out  NARGS x 32 ; apu_op_o out APU_WOP_CPU ; apu_flags_o out APU_NDSFLAGS_CPU
//  apu_tag_o      out  ID_W                     granted requester index
//  apu_rvalid_i   in   1 ; apu_rdata_i in 32 ; apu_rflags_i in APU_NUSFLAGS_CPU ; apu_rtag_i in ID_W
//  err_o          out  1                        sticky: response with tag of a requester that has no outstanding ops
// BEHAVIOUR
//  Reset: rr_ptr=0, all outst_cnt=0, err_o=0, gnt_o=0, rvalid_o=0, apu_req_o=0, registered resp regs 0.
//  Eligible[i] = req_i[i] && outst_cnt[i] != MAX_OUTST.
//  Winner: first eligible index scanning rr_ptr, rr_ptr+1 ... mod N_REQ (combinational, same cycle).
//  apu_req_o = |eligible; payload/tag muxed from winner; gnt_o[winner] = apu_gnt_i && apu_req_o.
//  Handshake (apu_req_o && apu_gnt_i): rr_ptr <= winner+1 (wrap N_REQ-1 -> 0); outst_cnt[winner]++.
//  No handshake: rr_ptr holds (winner may change if requests change; requesters hold req until gnt).
//  Response: rvalid_o[apu_rtag_i] = apu_rvalid_i (RESP_REG=0) or registered copy one cycle later (RESP_REG=1);
//   rdata_o/rflags_o follow the same timing. On apu_rvalid_i, outst_cnt[apu_rtag_i]-- at that edge in both modes.
//  Same-cycle grant and response for one requester: counter unchanged.
//  Response while outst_cnt[tag]==0: counter held at 0 (no underflow), rvalid still routed, err_o <= 1 until reset.
//  Counter at MAX_OUTST: requester masked; remaining requesters served; unmasked the cycle after a decrement.
//  Tag >= N_REQ (non-power-of-two N_REQ): response dropped, err_o <= 1.
//  Reset mid-operation: all state cleared immediately; in-flight FPU results after reset raise err_o.
// STRUCTURE
//  cv32e40p_apu_core_pkg: APU_* widths (already present). cv32e40p_pkg: add APU_ARB_MAX_REQ constant.
//  Sub-module cv32e40p_apu_rr_picker: N-bit request vector + rr_ptr -> one-hot winner + index, purely combinational.
//  Top holds rr_ptr, counter array, err flag, payload mux, response demux/optional register stage.
// TESTING
//  1. N_REQ=2, req_i=2'b11 held, apu_gnt_i=1 -> gnt_o alternates 01,10,01,10; apu_tag_o 0,1,0,1.
//  2. MAX_OUTST=4, req0 only, no responses -> 4 grants, then apu_req_o=0; one rvalid tag0 -> 5th grant next cycle.
//  3. apu_gnt_i=0 for 3 cycles with req_i=2'b10 -> gnt_o=0, payload stable from req1, rr_ptr unchanged.
//  4. Response tag1 rdata=32'hDEADBEEF -> rvalid_o=2'b10, rdata_o=DEADBEEF same cycle (RESP_REG=0), next cycle (RESP_REG=1).
//  5. Grant req0 and rvalid tag0 same cycle with outst_cnt[0]=2 -> outst_cnt[0] stays 2.
//  6. rvalid tag1 with outst_cnt[1]=0 -> err_o=1 next cycle and stays 1; rst_ni low -> err_o=0, counters 0.

Source files
------------

// File: rtl/cv32e40p_apu_arbiter_pkg.sv
// Shared APU widths, arbiter constants and bus payload types for the APU arbiter slice.
package cv32e40p_apu_arbiter_pkg;

  localparam int unsigned APU_NARGS_CPU    = 3;
  localparam int unsigned APU_WOP_CPU      = 6;
  localparam int unsigned APU_NDSFLAGS_CPU = 15;
  localparam int unsigned APU_NUSFLAGS_CPU = 5;

  // Upper bound on the number of requesters sharing one APU instance.
  localparam int unsigned APU_ARB_MAX_REQ  = 16;

  typedef struct packed {
    logic [APU_NARGS_CPU-1:0][31:0] operands;
    logic [APU_WOP_CPU-1:0]         op;
    logic [APU_NDSFLAGS_CPU-1:0]    flags;
  } apu_req_t;

  typedef struct packed {
    logic [31:0]                 rdata;
    logic [APU_NUSFLAGS_CPU-1:0] rflags;
  } apu_rsp_t;

  // Tag width for n requesters; never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cv32e40p_apu_arbiter_if.sv
// APU request/response channel between the arbiter (master) and the FPU wrapper (slave).
interface cv32e40p_apu_arbiter_if
  import cv32e40p_apu_arbiter_pkg::*;
#(
  parameter int unsigned ID_W = 1
);

  logic            req;
  logic            gnt;
  apu_req_t        payload;
  logic [ID_W-1:0] tag;

  logic            rvalid;
  apu_rsp_t        resp;
  logic [ID_W-1:0] rtag;

  modport master (
    output req, payload, tag,
    input  gnt, rvalid, resp, rtag
  );

  modport slave (
    input  req, payload, tag,
    output gnt, rvalid, resp, rtag
  );

endinterface

// File: rtl/cv32e40p_apu_rr_picker.sv
// Round-robin picker: first set request at or after ptr_i (wrapping), as one-hot and index.
module cv32e40p_apu_rr_picker #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             valid_o
);

  int unsigned     scan;
  logic [ID_W-1:0] sel;
  logic            found;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    scan     = 0;
    sel      = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan = (32'(ptr_i) + k) % N_REQ;
      sel  = ID_W'(scan);
      if (!found && req_i[sel]) begin
        found         = 1'b1;
        idx_o         = sel;
        onehot_o[sel] = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Shares one APU/FPU between N_REQ requesters: round-robin request arbitration, tag-based
// response demux and per-requester outstanding-op credits.
module cv32e40p_apu_arbiter
  import cv32e40p_apu_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned MAX_OUTST = 4,
  parameter bit          RESP_REG  = 1'b0
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,

  input  logic [N_REQ-1:0]                          req_i,
  output logic [N_REQ-1:0]                          gnt_o,
  input  logic [N_REQ-1:0][APU_NARGS_CPU-1:0][31:0] operands_i,
  input  logic [N_REQ-1:0][APU_WOP_CPU-1:0]         op_i,
  input  logic [N_REQ-1:0][APU_NDSFLAGS_CPU-1:0]    flags_i,

  output logic [N_REQ-1:0]                          rvalid_o,
  output logic [31:0]                               rdata_o,
  output logic [APU_NUSFLAGS_CPU-1:0]               rflags_o,

  cv32e40p_apu_arbiter_if.master                    apu,

  output logic                                      err_o
);

  localparam int unsigned     ID_W    = id_width(N_REQ);
  localparam int unsigned     CNT_W   = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

  logic [ID_W-1:0]             rr_ptr;
  logic [N_REQ-1:0][CNT_W-1:0] outst_cnt;
  logic [N_REQ-1:0][CNT_W-1:0] outst_cnt_nxt;
  logic                        err_q;
  logic                        err_nxt;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] win_oh;
  logic [ID_W-1:0]  win_idx;
  logic             win_valid;
  logic             handshake;
  logic             tag_ok;
  logic [N_REQ-1:0] rsp_hit;

  // A requester with all credits in flight is masked from arbitration.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      eligible[i] = req_i[i] && (outst_cnt[i] != CNT_MAX);
    end
  end

  cv32e40p_apu_rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_picker (
    .req_i    (eligible),
    .ptr_i    (rr_ptr),
    .onehot_o (win_oh),
    .idx_o    (win_idx),
    .valid_o  (win_valid)
  );

  assign apu.req     = win_valid;
  assign apu.tag     = win_idx;
  assign apu.payload = '{operands: operands_i[win_idx],
                         op:       op_i[win_idx],
                         flags:    flags_i[win_idx]};

  assign handshake = win_valid && apu.gnt;
  assign gnt_o     = handshake ? win_oh : '0;

  // Tags beyond N_REQ-1 only exist for non-power-of-two N_REQ and are dropped.
  assign tag_ok = 32'(apu.rtag) < N_REQ;

  always_comb begin
    rsp_hit = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rsp_hit[i] = apu.rvalid && tag_ok && (apu.rtag == ID_W'(i));
    end
  end

  // Credit update: grant and valid response in the same cycle cancel out.
  always_comb begin
    outst_cnt_nxt = outst_cnt;
    err_nxt       = err_q;
    if (apu.rvalid && !tag_ok) begin
      err_nxt = 1'b1;
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rsp_hit[i] && (outst_cnt[i] == '0)) begin
        err_nxt = 1'b1;
      end
      unique case ({gnt_o[i], rsp_hit[i] && (outst_cnt[i] != '0)})
        2'b10:   outst_cnt_nxt[i] = outst_cnt[i] + CNT_W'(1);
        2'b01:   outst_cnt_nxt[i] = outst_cnt[i] - CNT_W'(1);
        default: outst_cnt_nxt[i] = outst_cnt[i];
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr    <= '0;
      outst_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      outst_cnt <= outst_cnt_nxt;
      err_q     <= err_nxt;
      if (handshake) begin
        rr_ptr <= (win_idx == LAST_ID) ? '0 : win_idx + ID_W'(1);
      end
    end
  end

  assign err_o = err_q;

  // The FPU cannot be stalled, so responses are forwarded without any ready.
  if (RESP_REG) begin : g_resp_reg
    logic [N_REQ-1:0] rvalid_q;
    apu_rsp_t         rsp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rvalid_q <= '0;
        rsp_q    <= '0;
      end else begin
        rvalid_q <= rsp_hit;
        rsp_q    <= apu.resp;
      end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rsp_q.rdata;
    assign rflags_o = rsp_q.rflags;
  end else begin : g_resp_comb
    assign rvalid_o = rsp_hit;
    assign rdata_o  = apu.resp.rdata;
    assign rflags_o = apu.resp.rflags;
  end

endmodule
